// File: rtl/demux_wr_sched.sv
// demux_wr_sched: round-robin arbiter for the shared 1-to-8 demux write path.
// One eligible requester per cycle is granted.
// The chosen destination, data and one-hot strobe are registered for the demux.
module demux_wr_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [3*N_REQ-1:0]   req_dst,
  input  logic [W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_lock,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [7:0]           dst_ready,
  output logic [2:0]           dm_s,
  output logic [W-1:0]         dm_d,
  output logic [7:0]           wr_en,
  output logic [15:0]          xfer_cnt
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [2:0]       dm_s_q, dm_s_d;
  logic [W-1:0]     dm_d_q, dm_d_d;
  logic [7:0]       wr_en_q, wr_en_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic             hi_found, lo_found, g_found;
  logic [PW-1:0]    hi_idx, lo_idx, g_idx;
  logic [2:0]       g_dst;
  logic [W-1:0]     g_data;
  logic             g_lock;

  // A requester is eligible when valid and its destination can accept a write.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] & dst_ready[req_dst[3*i +: 3]];
    end
  end

  // Rotating priority search starting at ptr.
  // The search is split into two fixed-order encoders.
  // The first covers indices at or above ptr and the second covers indices below it.
  // The upper range wins, which matches a circular search.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (elig[i] && (i >= 32'(ptr_q)) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = PW'(i);
      end
      if (elig[i] && (i < 32'(ptr_q)) && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
      end
    end
    g_found = hi_found | lo_found;
    g_idx   = hi_found ? hi_idx : lo_idx;
  end

  // One-hot grant plus the granted requester's destination, data and lock.
  always_comb begin
    grant  = '0;
    g_dst  = '0;
    g_data = '0;
    g_lock = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant[i] = g_found && (32'(g_idx) == i);
      if (grant[i]) begin
        g_dst  = req_dst[3*i +: 3];
        g_data = req_data[W*i +: W];
        g_lock = req_lock[i];
      end
    end
  end

  assign req_ready = grant;

  // Next-state: pointer rotation or retention, output capture, transfer count.
  always_comb begin
    ptr_d   = ptr_q;
    dm_s_d  = dm_s_q;
    dm_d_d  = dm_d_q;
    wr_en_d = '0;
    cnt_d   = cnt_q;
    if (g_found) begin
      if (g_lock) begin
        ptr_d = g_idx;
      end else if (32'(g_idx) == N_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = g_idx + 1'b1;
      end
      dm_s_d  = g_dst;
      dm_d_d  = g_data;
      wr_en_d = 8'b1 << g_dst;
      cnt_d   = cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      dm_s_q  <= '0;
      dm_d_q  <= '0;
      wr_en_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      dm_s_q  <= dm_s_d;
      dm_d_q  <= dm_d_d;
      wr_en_q <= wr_en_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dm_s     = dm_s_q;
  assign dm_d     = dm_d_q;
  assign wr_en    = wr_en_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux_wr_sched.sv
// Testbench for demux_wr_sched.
// The bench drives directed scenarios, then random traffic, then a counter wrap.
// A behavioural model is compared against the DUT every cycle.
module tb_demux_wr_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [3*N-1:0] req_dst = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]  req_lock = '0;
  logic [N-1:0]  req_ready;
  logic [7:0]    dst_ready = 8'hFF;
  logic [2:0]    dm_s;
  logic [31:0]   dm_d;
  logic [7:0]    wr_en;
  logic [15:0]   xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: pointer and the expected registered outputs.
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [2:0]  m_dm_s = '0;
  logic [31:0] m_dm_d = '0;
  logic [7:0]  m_wr_en = '0;

  demux_wr_sched #(.N_REQ(N), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dst(req_dst), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .dst_ready(dst_ready),
    .dm_s(dm_s), .dm_d(dm_d), .wr_en(wr_en), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Circular search from the model pointer; -1 means nobody eligible.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i] && dst_ready[req_dst[3*i +: 3]]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_cnt = 0; m_dm_s = '0; m_dm_d = '0; m_wr_en = '0;
    end else begin
      int g;
      g = pick();
      if (g >= 0) begin
        m_dm_s  = req_dst[3*g +: 3];
        m_dm_d  = req_data[32*g +: 32];
        m_wr_en = 8'd1 << m_dm_s;
        m_cnt   = (m_cnt + 1) % 65536;
        m_ptr   = req_lock[g] ? g : (g + 1) % N;
      end else begin
        m_wr_en = '0;
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g  = pick();
    er = (g < 0) ? '0 : N'(1 << g);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("dm_s", 64'(dm_s), 64'(m_dm_s));
    chk("dm_d", 64'(dm_d), 64'(m_dm_d));
    chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] d,
                         input logic [31:0] dat, input logic l);
    req_valid[i]        = v;
    req_dst[3*i +: 3]   = d;
    req_data[32*i +: 32] = dat;
    req_lock[i]         = l;
  endtask

  task automatic all_rr();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i), 32'hA0 + 32'(i), 1'b0);
    dst_ready = 8'hFF;
  endtask

  initial begin
    // Reset state while all requesters are valid.
    all_rr();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_dm_s", 64'(dm_s), 64'h0);
    chk("rst_dm_d", 64'(dm_d), 64'h0);
    chk("rst_cnt", 64'(xfer_cnt), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'b0001);
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 64'(req_ready), 64'b0001);

    // Round-robin fairness.
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_wr_en", 64'(wr_en), 64'(8'd1 << k));
      chk("rr_dm_d", 64'(dm_d), 64'h0A0 + 64'(k));
      chk("rr_ready", 64'(req_ready), 64'(1 << ((k + 1) % 4)));
    end

    // Destination skip (ptr = 0).
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 3'd0, 32'h0, 1'b0);
    set_req(0, 1'b1, 3'd5, 32'h0000_0B05, 1'b0);
    set_req(1, 1'b1, 3'd2, 32'h0000_0B12, 1'b0);
    dst_ready = 8'hDF;
    #1 chk("skip_ready", 64'(req_ready), 64'b0010);
    tick();
    chk("skip_wr_en", 64'(wr_en), 64'h04);
    dst_ready = 8'hFF;
    #1 chk("skip_wrap_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("skip_wrap_wr_en", 64'(wr_en), 64'h20);
    chk("skip_wrap_dm_s", 64'(dm_s), 64'd5);

    // Lock retention (ptr = 1).
    set_req(0, 1'b1, 3'd0, 32'hA0, 1'b0);
    set_req(1, 1'b1, 3'd1, 32'hA1, 1'b0);
    set_req(2, 1'b1, 3'd7, 32'h1234_5678, 1'b1);
    set_req(3, 1'b1, 3'd3, 32'hA3, 1'b0);
    #1 chk("lock_pre_ready", 64'(req_ready), 64'b0010);
    tick();
    chk("lock_ready0", 64'(req_ready), 64'b0100);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("lock_wr_en", 64'(wr_en), 64'h80);
      chk("lock_dm_d", 64'(dm_d), 64'h1234_5678);
      chk("lock_ready", 64'(req_ready), 64'b0100);
    end
    req_lock[2] = 1'b0;
    tick();
    chk("unlock_ready", 64'(req_ready), 64'b1000);

    // Idle hold after a transfer (ptr = 3).
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 3'd0, 32'h0, 1'b0);
    set_req(3, 1'b1, 3'd6, 32'hDEAD_BEEF, 1'b0);
    tick();
    chk("idle_xfer_wr_en", 64'(wr_en), 64'h40);
    req_valid = '0;
    tick();
    chk("idle_wr_en", 64'(wr_en), 64'h0);
    chk("idle_dm_s", 64'(dm_s), 64'd6);
    chk("idle_dm_d", 64'(dm_d), 64'hDEAD_BEEF);
    chk("idle_cnt", 64'(xfer_cnt), 64'd11);
    tick();
    all_rr();
    #1 chk("idle_ptr", 64'(req_ready), 64'b0001);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      tick();
      req_valid = N'($urandom);
      req_lock  = N'($urandom & $urandom);
      req_dst   = (3*N)'($urandom);
      for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
      dst_ready = 8'($urandom | $urandom);
    end

    // Counter wrap, then asynchronous reset during a write pulse.
    all_rr();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (65535) tick();
    chk("cnt_ffff", 64'(xfer_cnt), 64'hFFFF);
    tick();
    chk("cnt_wrap", 64'(xfer_cnt), 64'h0000);
    chk("wrap_pulse", 64'(wr_en != 8'h00), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_wr_en", 64'(wr_en), 64'h0);
    chk("async_cnt", 64'(xfer_cnt), 64'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
